// File: rtl/tick_timer.sv
// Programmable tick generator: periodic or one-shot pulse every max(period,1) clocks.
// Define TIMER_STEP_EN to add the `step` port for forced single ticks.
module tick_timer #(
  parameter int WIDTH = 24,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 24'd12_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             ena,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
`ifdef TIMER_STEP_EN
  input  logic             step,
`endif
  output logic             output_pulse,
  output logic             running,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic [WIDTH-1:0] last;

  // A zero period behaves as one, so the wrap point is 0 in both cases.
  assign last = (period_q == '0) ? '0 : period_q - ONE;

  assign running = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      period_q     <= DEFAULT_PERIOD;
      mode_q       <= 1'b0;
      output_pulse <= 1'b0;
    end else begin
      output_pulse <= 1'b0;
      if (stop) begin
        state <= IDLE;
        count <= '0;
      end else if (load) begin
        period_q <= period;
        count    <= '0;
`ifdef TIMER_STEP_EN
      end else if (step) begin
        output_pulse <= 1'b1;
        count        <= '0;
        if (state == RUN && mode_q) begin
          state <= IDLE;
        end
`endif
      end else if (start) begin
        state  <= RUN;
        count  <= '0;
        mode_q <= oneshot;
      end else begin
        unique case (state)
          IDLE: begin
            count <= '0;
          end
          RUN: begin
            if (!ena) begin
              state <= PAUSED;
            end else if (count == last) begin
              count        <= '0;
              output_pulse <= 1'b1;
              if (mode_q) begin
                state <= IDLE;
              end
            end else begin
              count <= count + ONE;
            end
          end
          PAUSED: begin
            if (ena) begin
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule
